// File: rtl/mem_lsu_pipe_if.sv
// Request, writeback and performance-counter signals of mem_lsu_pipe.
// slave = the load/store unit, master = the pipeline driving it.
interface mem_lsu_pipe_if #(
   parameter int XLEN = 64
);
   logic            i_valid;
   logic            o_ready;
   logic            i_is_load;
   logic            i_is_store;
   logic [2:0]      i_funct3;
   logic [XLEN-1:0] i_addr;
   logic [XLEN-1:0] i_wdata;
   logic [4:0]      i_rd;
   logic            i_rd_we;
   logic            i_kill;
   logic            o_valid;
   logic            i_wb_ready;
   logic [XLEN-1:0] o_rdata;
   logic [4:0]      o_rd;
   logic            o_rd_we;
   logic            o_load_misaligned;
   logic            o_store_misaligned;
   logic            o_illegal;
   logic [31:0]     o_load_cnt;
   logic [31:0]     o_store_cnt;

   modport slave (
      input  i_valid, i_is_load, i_is_store, i_funct3, i_addr, i_wdata,
      input  i_rd, i_rd_we, i_kill, i_wb_ready,
      output o_ready, o_valid, o_rdata, o_rd, o_rd_we,
      output o_load_misaligned, o_store_misaligned, o_illegal,
      output o_load_cnt, o_store_cnt
   );

   modport master (
      output i_valid, i_is_load, i_is_store, i_funct3, i_addr, i_wdata,
      output i_rd, i_rd_we, i_kill, i_wb_ready,
      input  o_ready, o_valid, o_rdata, o_rd, o_rd_we,
      input  o_load_misaligned, o_store_misaligned, o_illegal,
      input  o_load_cnt, o_store_cnt
   );
endinterface

// File: rtl/mem_lsu_pipe.sv
// Single-cycle load/store unit over an inferred byte-enabled RAM with a one-entry output stage.
// Define MEM_LSU_PERF_CNT_EN to build the accepted load/store counters; otherwise they read 0.
module mem_lsu_pipe #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 1024
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_lsu_pipe_if.slave bus
);
   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);
   localparam int AW   = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_FRESH,
      ST_HELD
   } state_t;

   state_t state_reg, state_next;

   logic            op_store, op_load, op_mem;
   logic [1:0]      size;
   logic            illegal, misaligned, misaligned_raw, access_ok;
   logic [OFFW-1:0] offset;
   logic [AW-1:0]   word_idx;
   logic            accept, take, mem_we, mem_re;
   logic [NB-1:0]   size_be, byte_en;
   logic [XLEN-1:0] wdata_lane;
   logic            unused_addr_bits;

   assign op_store = bus.i_is_store;
   assign op_load  = bus.i_is_load && !bus.i_is_store;
   assign op_mem   = op_load || op_store;
   assign size     = bus.i_funct3[1:0];
   assign offset   = bus.i_addr[OFFW-1:0];
   assign word_idx = bus.i_addr[AW+OFFW-1:OFFW];

   // Upper address bits wrap around the array.
   assign unused_addr_bits = ^bus.i_addr[XLEN-1:AW+OFFW];

   always_comb begin
      illegal = 1'b0;
      if (op_mem) begin
         if (bus.i_funct3 == 3'b111) begin
            illegal = 1'b1;
         end else if (XLEN == 32 && (bus.i_funct3 == 3'b011 || bus.i_funct3 == 3'b110)) begin
            illegal = 1'b1;
         end
      end
   end

   always_comb begin
      misaligned_raw = 1'b0;
      case (size)
         2'b01:   misaligned_raw = bus.i_addr[0];
         2'b10:   misaligned_raw = |bus.i_addr[1:0];
         2'b11:   misaligned_raw = |bus.i_addr[2:0];
         default: misaligned_raw = 1'b0;
      endcase
   end

   assign misaligned = op_mem && !illegal && misaligned_raw;
   assign access_ok  = op_mem && !illegal && !misaligned;

   assign accept = bus.i_valid && bus.o_ready;
   assign take   = accept && !bus.i_kill;
   assign mem_we = take && rst_n && op_store && access_ok;
   assign mem_re = take && rst_n && op_load && access_ok;

   always_comb begin
      size_be = '0;
      case (size)
         2'b00:   size_be = NB'(1);
         2'b01:   size_be = NB'(3);
         2'b10:   size_be = NB'(15);
         default: size_be = '1;
      endcase
   end

   assign byte_en    = size_be << offset;
   assign wdata_lane = bus.i_wdata << {offset, 3'b000};

   logic [XLEN-1:0] mem [DEPTH];
   logic [XLEN-1:0] rd_word_reg;

   // Loads and stores never share a cycle, so read-during-write ordering never matters.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (byte_en[b]) begin
               mem[word_idx][b*8 +: 8] <= wdata_lane[b*8 +: 8];
            end
         end
      end
      if (mem_re) begin
         rd_word_reg <= mem[word_idx];
      end
   end

   logic            ld_ok_reg, unsigned_reg, rd_we_reg;
   logic            lmis_reg, smis_reg, ill_reg;
   logic [1:0]      size_reg;
   logic [OFFW-1:0] off_reg;
   logic [4:0]      rd_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ld_ok_reg    <= 1'b0;
         unsigned_reg <= 1'b0;
         rd_we_reg    <= 1'b0;
         lmis_reg     <= 1'b0;
         smis_reg     <= 1'b0;
         ill_reg      <= 1'b0;
         size_reg     <= '0;
         off_reg      <= '0;
         rd_reg       <= '0;
      end else if (accept) begin
         ld_ok_reg    <= op_load && access_ok;
         unsigned_reg <= bus.i_funct3[2];
         rd_we_reg    <= bus.i_rd_we && !op_store && !illegal && !misaligned;
         lmis_reg     <= op_load && misaligned;
         smis_reg     <= op_store && misaligned;
         ill_reg      <= illegal;
         size_reg     <= size;
         off_reg      <= offset;
         rd_reg       <= bus.i_rd;
      end
   end

   logic [XLEN-1:0] lane_word, ext_mask, fresh_data;
   logic            sign_bit;

   always_comb begin
      lane_word = rd_word_reg >> {off_reg, 3'b000};
      ext_mask  = '1;
      sign_bit  = lane_word[XLEN-1];
      case (size_reg)
         2'b00: begin
            ext_mask = XLEN'(64'h0000_0000_0000_00FF);
            sign_bit = lane_word[7];
         end
         2'b01: begin
            ext_mask = XLEN'(64'h0000_0000_0000_FFFF);
            sign_bit = lane_word[15];
         end
         2'b10: begin
            ext_mask = XLEN'(64'h0000_0000_FFFF_FFFF);
            sign_bit = lane_word[31];
         end
         default: begin
            ext_mask = '1;
            sign_bit = lane_word[XLEN-1];
         end
      endcase
      fresh_data = lane_word & ext_mask;
      if (!unsigned_reg && sign_bit) begin
         fresh_data = fresh_data | ~ext_mask;
      end
      if (!ld_ok_reg) begin
         fresh_data = '0;
      end
   end

   logic            hold_load;
   logic [XLEN-1:0] hold_reg;

   always_comb begin
      state_next = state_reg;
      hold_load  = 1'b0;
      case (state_reg)
         ST_EMPTY: begin
            if (accept) begin
               state_next = take ? ST_FRESH : ST_EMPTY;
            end
         end
         ST_FRESH: begin
            if (bus.i_wb_ready) begin
               state_next = take ? ST_FRESH : ST_EMPTY;
            end else begin
               state_next = ST_HELD;
               hold_load  = 1'b1;
            end
         end
         ST_HELD: begin
            if (bus.i_wb_ready) begin
               state_next = take ? ST_FRESH : ST_EMPTY;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_EMPTY;
         hold_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (hold_load) begin
            hold_reg <= fresh_data;
         end
      end
   end

   logic out_valid;

   assign out_valid   = (state_reg != ST_EMPTY);
   assign bus.o_valid = out_valid;
   assign bus.o_ready = !out_valid || bus.i_wb_ready;
   assign bus.o_rd    = rd_reg;

   // The hold register decouples the stalled result from the RAM output register.
   assign bus.o_rdata = (state_reg == ST_HELD)  ? hold_reg   :
                        (state_reg == ST_FRESH) ? fresh_data : '0;

   assign bus.o_rd_we            = out_valid && rd_we_reg;
   assign bus.o_load_misaligned  = out_valid && lmis_reg;
   assign bus.o_store_misaligned = out_valid && smis_reg;
   assign bus.o_illegal          = out_valid && ill_reg;

`ifdef MEM_LSU_PERF_CNT_EN
   logic [31:0] load_cnt_reg, store_cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         load_cnt_reg  <= '0;
         store_cnt_reg <= '0;
      end else begin
         if (mem_re) begin
            load_cnt_reg <= load_cnt_reg + 32'd1;
         end
         if (mem_we) begin
            store_cnt_reg <= store_cnt_reg + 32'd1;
         end
      end
   end

   assign bus.o_load_cnt  = load_cnt_reg;
   assign bus.o_store_cnt = store_cnt_reg;
`else
   assign bus.o_load_cnt  = '0;
   assign bus.o_store_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_lsu_pipe.sv
// Directed and randomized checks of mem_lsu_pipe against a byte-array reference model.
// Expected counter values follow MEM_LSU_PERF_CNT_EN.
module tb_mem_lsu_pipe;
   localparam int XLEN  = 64;
   localparam int DEPTH = 1024;
   localparam int MEMB  = DEPTH * 8;

`ifdef MEM_LSU_PERF_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mem_lsu_pipe_if #(.XLEN(XLEN)) bus ();

   mem_lsu_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      bit          valid;
      logic [63:0] rdata;
      logic [4:0]  rd;
      bit          rd_we;
      bit          lmis;
      bit          smis;
      bit          ill;
   } res_t;

   res_t        cur;
   logic [7:0]  mem_b [MEMB];
   logic [31:0] exp_lcnt;
   logic [31:0] exp_scnt;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: memory is a flat byte array, sizes are byte counts, extension is arithmetic.
   task automatic model_op(input bit ld, input bit st, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [4:0] rd, input bit rdwe, output res_t r);
      int          nbytes;
      int          base;
      logic [63:0] val;
      r       = '0;
      r.valid = 1'b1;
      r.rd    = rd;
      nbytes  = 1 << f3[1:0];
      if (ld || st) begin
         if (f3 == 3'b111) r.ill = 1'b1;
         else if ((addr % 64'(nbytes)) != 0) begin
            if (st) r.smis = 1'b1;
            else    r.lmis = 1'b1;
         end
      end
      r.rd_we = rdwe && !st && !r.ill && !r.lmis;
      base    = int'(addr % 64'(MEMB));
      if (st && !r.ill && !r.smis) begin
         for (int b = 0; b < nbytes; b++) mem_b[base + b] = wdata[8*b +: 8];
         exp_scnt++;
      end else if (ld && !r.ill && !r.lmis) begin
         val = '0;
         for (int b = 0; b < nbytes; b++) val = val | (64'(mem_b[base + b]) << (8 * b));
         if (!f3[2] && nbytes < 8 && val[8*nbytes-1]) val = val | (~64'h0 << (8 * nbytes));
         r.rdata = val;
         exp_lcnt++;
      end
   endtask

   task automatic compare_out();
      check("o_valid", 64'(bus.o_valid), 64'(cur.valid));
      if (cur.valid) begin
         check("o_rdata", bus.o_rdata, cur.rdata);
         check("o_rd", 64'(bus.o_rd), 64'(cur.rd));
         check("o_rd_we", 64'(bus.o_rd_we), 64'(cur.rd_we));
         check("o_load_misaligned", 64'(bus.o_load_misaligned), 64'(cur.lmis));
         check("o_store_misaligned", 64'(bus.o_store_misaligned), 64'(cur.smis));
         check("o_illegal", 64'(bus.o_illegal), 64'(cur.ill));
      end
      check("o_load_cnt", 64'(bus.o_load_cnt), CNT_EN ? 64'(exp_lcnt) : 64'd0);
      check("o_store_cnt", 64'(bus.o_store_cnt), CNT_EN ? 64'(exp_scnt) : 64'd0);
   endtask

   task automatic step(input bit v, input bit ld, input bit st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [4:0] rd, input bit rdwe, input bit kill, input bit wbr);
      res_t nxt;
      bit   acc;
      bus.i_valid    = v;
      bus.i_is_load  = ld;
      bus.i_is_store = st;
      bus.i_funct3   = f3;
      bus.i_addr     = addr;
      bus.i_wdata    = wdata;
      bus.i_rd       = rd;
      bus.i_rd_we    = rdwe;
      bus.i_kill     = kill;
      bus.i_wb_ready = wbr;
      #1;
      check("o_ready", 64'(bus.o_ready), 64'(!cur.valid || wbr));
      acc = v && (!cur.valid || wbr);
      nxt = '0;
      if (acc) begin
         if (!kill) model_op(ld, st, f3, addr, wdata, rd, rdwe, nxt);
      end else if (!(cur.valid && wbr)) begin
         nxt = cur;
      end
      @(posedge clk);
      #1;
      cur = nxt;
      compare_out();
      $display("op v=%0d ld=%0d st=%0d f3=%0d addr=%h wdata=%h kill=%0d wbr=%0d acc=%0d -> valid=%0d rdata=%h",
               v, ld, st, f3, addr, wdata, kill, wbr, acc, bus.o_valid, bus.o_rdata);
   endtask

   // Reset asserted with a store offered: nothing may be written, all outputs clear.
   task automatic do_reset();
      rst_n = 1'b0;
      bus.i_valid    = 1'b1;
      bus.i_is_load  = 1'b0;
      bus.i_is_store = 1'b1;
      bus.i_funct3   = 3'b011;
      bus.i_addr     = 64'h100;
      bus.i_wdata    = 64'hBADBADBADBADBAD0;
      bus.i_rd       = 5'd3;
      bus.i_rd_we    = 1'b1;
      bus.i_kill     = 1'b0;
      bus.i_wb_ready = 1'b1;
      @(posedge clk);
      #1;
      cur      = '0;
      exp_lcnt = '0;
      exp_scnt = '0;
      check("rst_o_valid", 64'(bus.o_valid), 64'd0);
      check("rst_o_rd", 64'(bus.o_rd), 64'd0);
      check("rst_o_rd_we", 64'(bus.o_rd_we), 64'd0);
      check("rst_flags", {61'd0, bus.o_load_misaligned, bus.o_store_misaligned, bus.o_illegal}, 64'd0);
      check("rst_o_rdata", bus.o_rdata, 64'd0);
      check("rst_cnt", {bus.o_load_cnt, bus.o_store_cnt}, 64'd0);
      $display("reset applied with store offered -> valid=%0d rdata=%h", bus.o_valid, bus.o_rdata);
      rst_n = 1'b1;
      bus.i_valid = 1'b0;
   endtask

   initial begin
      bit          v, ld, st, kill, wbr, rdwe;
      int          kind;
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [4:0]  rd;

      for (int i = 0; i < MEMB; i++) mem_b[i] = 8'h00;
      cur = '0;
      do_reset();

      for (int w = 0; w < 64; w++)
         step(1, 0, 1, 3'b011, 64'(w * 8), {$urandom, $urandom}, 5'd0, 0, 0, 1);

      step(1, 0, 1, 3'b011, 64'h100, 64'h1122334455667788, 5'd1, 0, 0, 1);
      step(1, 1, 0, 3'b011, 64'h100, 64'h0, 5'd10, 1, 0, 1);
      check("req030_ld", bus.o_rdata, 64'h1122334455667788);

      step(1, 0, 1, 3'b000, 64'h107, 64'h81, 5'd0, 0, 0, 1);
      step(1, 1, 0, 3'b000, 64'h107, 64'h0, 5'd11, 1, 0, 1);
      check("req031_lb", bus.o_rdata, 64'hFFFFFFFFFFFFFF81);
      step(1, 1, 0, 3'b100, 64'h107, 64'h0, 5'd11, 1, 0, 1);
      check("req031_lbu", bus.o_rdata, 64'h81);

      step(1, 1, 0, 3'b010, 64'h102, 64'h0, 5'd12, 1, 0, 1);
      check("req032_lmis", 64'(bus.o_load_misaligned), 64'd1);
      check("req032_lmis_rd_we", 64'(bus.o_rd_we), 64'd0);
      step(1, 0, 1, 3'b001, 64'h101, 64'hFFFF, 5'd0, 0, 0, 1);
      check("req032_smis", 64'(bus.o_store_misaligned), 64'd1);
      step(1, 1, 0, 3'b011, 64'h100, 64'h0, 5'd12, 1, 0, 1);
      check("req032_unchanged", bus.o_rdata, 64'h8122334455667788);

      step(1, 1, 0, 3'b011, 64'h100, 64'h0, 5'd13, 1, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 1, 3'b011, 64'h100, 64'hCAFEF00D12345678, 5'd0, 0, 0, 0);
         check("req033_hold_rdata", bus.o_rdata, 64'h8122334455667788);
         check("req033_hold_ready", 64'(bus.o_ready), 64'd0);
      end
      step(1, 0, 1, 3'b011, 64'h100, 64'hCAFEF00D12345678, 5'd0, 0, 0, 1);
      step(1, 1, 0, 3'b011, 64'h100, 64'h0, 5'd14, 1, 0, 1);
      check("req033_store_after_release", bus.o_rdata, 64'hCAFEF00D12345678);

      step(1, 0, 1, 3'b011, 64'h2000, 64'h0123456789ABCDEF, 5'd0, 0, 0, 1);
      step(1, 1, 0, 3'b011, 64'h0, 64'h0, 5'd15, 1, 0, 1);
      check("req034_alias", bus.o_rdata, 64'h0123456789ABCDEF);

      step(1, 0, 1, 3'b011, 64'h8, 64'hDEADDEADDEADDEAD, 5'd0, 0, 1, 1);
      check("req034_kill_valid", 64'(bus.o_valid), 64'd0);
      step(1, 1, 0, 3'b011, 64'h8, 64'h0, 5'd16, 1, 0, 1);

      step(1, 0, 0, 3'b000, 64'h55, 64'h77, 5'd5, 1, 0, 1);
      check("nonmem_rd", {bus.o_rdata[58:0], bus.o_rd}, 64'd5);
      check("nonmem_rd_we", 64'(bus.o_rd_we), 64'd1);
      step(1, 1, 0, 3'b111, 64'h100, 64'h0, 5'd6, 1, 0, 1);
      check("illegal_f3", 64'(bus.o_illegal), 64'd1);

      step(1, 1, 0, 3'b011, 64'h100, 64'h0, 5'd7, 1, 0, 0);
      do_reset();
      step(1, 1, 0, 3'b011, 64'h100, 64'h0, 5'd8, 1, 0, 1);
      check("req027_no_write", bus.o_rdata, 64'hCAFEF00D12345678);

      for (int n = 0; n < 400; n++) begin
         v     = ($urandom_range(0, 9) < 8);
         kind  = int'($urandom_range(0, 9));
         ld    = (kind < 4);
         st    = (kind >= 4 && kind < 8);
         f3    = 3'($urandom_range(0, 7));
         addr  = ({$urandom, $urandom} & ~64'h1FFF) | 64'($urandom_range(0, 511));
         wdata = {$urandom, $urandom};
         rd    = 5'($urandom_range(0, 31));
         rdwe  = $urandom_range(0, 1) == 1;
         kill  = ($urandom_range(0, 9) == 0);
         wbr   = ($urandom_range(0, 3) != 0);
         step(v, ld, st, f3, addr, wdata, rd, rdwe, kill, wbr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
